// File: rtl/sobel_gcd_spi_pkg.sv
// Shared types and command-field constants for the sobel_gcd SPI master.
package sobel_gcd_spi_pkg;

    localparam int STREAM_DATA_WIDTH = 16;

    // Command word fields understood by the sobel_gcd slave
    localparam int         SOBEL_BIT = 15;
    localparam int         OPSEL_MSB = 14;
    localparam int         OPSEL_LSB = 13;
    localparam logic [1:0] OPSEL_A   = 2'b00;
    localparam logic [1:0] OPSEL_B   = 2'b01;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_GAP
    } state_e;

endpackage

// File: rtl/spi_master_sck_gen.sv
// SCK generator: divides clk_i into CLK_DIV-cycle half periods while enabled,
// and flags the cycle whose edge makes SCK rise or fall.
module spi_master_sck_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic nreset_i,
    input  logic en_i,
    output logic sck_o,
    output logic sck_rise_o,
    output logic sck_fall_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q;
    logic          wrap;

    assign wrap       = en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign sck_rise_o = wrap && !sck_o;
    assign sck_fall_o = wrap && sck_o;

    // Half-period counter; SCK toggles on wrap and is parked low when disabled
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            cnt_q <= '0;
            sck_o <= 1'b0;
        end else if (!en_i) begin
            cnt_q <= '0;
            sck_o <= 1'b0;
        end else if (wrap) begin
            cnt_q <= '0;
            sck_o <= !sck_o;
        end else begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

endmodule

// File: rtl/sobel_gcd_spi_master.sv
// SPI Mode-0 initiator: one command word per chip-select frame, wire order is
// low byte first, MSB first within each byte. The returned word is presented
// with a one-cycle rsp_valid_o pulse as CS rises.
module sobel_gcd_spi_master
    import sobel_gcd_spi_pkg::*;
#(
    parameter int WORD_SIZE = STREAM_DATA_WIDTH,
    parameter int CLK_DIV   = 4,
    parameter int CS_SETUP  = 2,
    parameter int CS_HOLD   = 2,
    parameter int CS_GAP    = 4
) (
    input  logic                 clk_i,
    input  logic                 nreset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [WORD_SIZE-1:0] cmd_data_i,
    output logic                 rsp_valid_o,
    output logic [WORD_SIZE-1:0] rsp_data_o,
    output logic                 busy_o,
    output logic                 spi_sck_o,
    output logic                 spi_cs_o,
    output logic                 spi_sdi_o,
    input  logic                 spi_sdo_i
);

    localparam int BW   = $clog2(WORD_SIZE);
    localparam int TMAX = (CS_SETUP > CS_HOLD) ?
                          ((CS_SETUP > CS_GAP) ? CS_SETUP : CS_GAP) :
                          ((CS_HOLD  > CS_GAP) ? CS_HOLD  : CS_GAP);
    localparam int TW   = $clog2(TMAX + 1);

    state_e               state_q, state_d;
    logic [TW-1:0]        tmr_q, tmr_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [WORD_SIZE-1:0] tx_q, rx_q;
    logic                 sck_rise, sck_fall;
    logic                 accept, last_fall, hold_done;
    logic [BW-1:0]        nxt_idx, rx_idx;

    // Wire bit k maps to word bit k^7: bytes in ascending order, bits MSB first
    assign nxt_idx = (bit_q + BW'(1)) ^ BW'(7);
    assign rx_idx  = bit_q ^ BW'(7);

    spi_master_sck_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_sck_gen (
        .clk_i     (clk_i),
        .nreset_i  (nreset_i),
        .en_i      (state_q == S_SHIFT),
        .sck_o     (spi_sck_o),
        .sck_rise_o(sck_rise),
        .sck_fall_o(sck_fall)
    );

    // Next-state logic: phase timer for setup/hold/gap, bit counter on SCK falls
    always_comb begin
        state_d   = state_q;
        tmr_d     = tmr_q + TW'(1);
        bit_d     = bit_q;
        accept    = 1'b0;
        last_fall = 1'b0;
        hold_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                tmr_d = '0;
                if (cmd_valid_i && cmd_ready_o) begin
                    accept  = 1'b1;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (tmr_q == TW'(CS_SETUP - 1)) begin
                    state_d = S_SHIFT;
                    tmr_d   = '0;
                end
            end
            S_SHIFT: begin
                tmr_d = '0;
                if (sck_fall) begin
                    if (bit_q == BW'(WORD_SIZE - 1)) begin
                        bit_d     = '0;
                        last_fall = 1'b1;
                        state_d   = S_HOLD;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            S_HOLD: begin
                if (tmr_q == TW'(CS_HOLD - 1)) begin
                    hold_done = 1'b1;
                    state_d   = S_GAP;
                    tmr_d     = '0;
                end
            end
            S_GAP: begin
                if (tmr_q == TW'(CS_GAP - 1)) begin
                    state_d = S_IDLE;
                    tmr_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                tmr_d   = '0;
            end
        endcase
    end

    // State, shift registers and registered outputs derived from the next state
    always_ff @(posedge clk_i or negedge nreset_i) begin
        if (!nreset_i) begin
            state_q     <= S_IDLE;
            tmr_q       <= '0;
            bit_q       <= '0;
            tx_q        <= '0;
            rx_q        <= '0;
            spi_cs_o    <= 1'b1;
            spi_sdi_o   <= 1'b0;
            cmd_ready_o <= 1'b0;
            busy_o      <= 1'b0;
            rsp_valid_o <= 1'b0;
            rsp_data_o  <= '0;
        end else begin
            state_q     <= state_d;
            tmr_q       <= tmr_d;
            bit_q       <= bit_d;
            spi_cs_o    <= !(state_d inside {S_SETUP, S_SHIFT, S_HOLD});
            cmd_ready_o <= (state_d == S_IDLE);
            busy_o      <= (state_d != S_IDLE);
            rsp_valid_o <= hold_done;
            if (accept) begin
                tx_q      <= cmd_data_i;
                spi_sdi_o <= cmd_data_i[7];
            end else if (sck_fall && !last_fall) begin
                spi_sdi_o <= tx_q[nxt_idx];
            end else if (hold_done) begin
                spi_sdi_o <= 1'b0;
            end
            if (sck_rise) begin
                rx_q[rx_idx] <= spi_sdo_i;
            end
            if (hold_done) begin
                rsp_data_o <= rx_q;
            end
        end
    end

endmodule

// File: tb/tb_sobel_gcd_spi_master.sv
// Bench for sobel_gcd_spi_master: behavioural SPI slave plus a frame-timeline
// model checked every cycle, and directed scenarios with literal expectations.
module tb_sobel_gcd_spi_master;
    import sobel_gcd_spi_pkg::*;

    localparam int W = 16;

    logic         clk_i = 1'b0;
    logic         nreset_i = 1'b1;
    logic         cmd_valid_i = 1'b0;
    logic [W-1:0] cmd_data_i = '0;
    logic         spi_sdo_i = 1'b0;
    logic         cmd_ready_o, rsp_valid_o, busy_o;
    logic [W-1:0] rsp_data_o;
    logic         spi_sck_o, spi_cs_o, spi_sdi_o;

    always #5 clk_i = ~clk_i;

    sobel_gcd_spi_master dut (
        .clk_i      (clk_i),
        .nreset_i   (nreset_i),
        .cmd_valid_i(cmd_valid_i),
        .cmd_ready_o(cmd_ready_o),
        .cmd_data_i (cmd_data_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_data_o (rsp_data_o),
        .busy_o     (busy_o),
        .spi_sck_o  (spi_sck_o),
        .spi_cs_o   (spi_cs_o),
        .spi_sdi_o  (spi_sdi_o),
        .spi_sdo_i  (spi_sdo_i)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // k-th bit on the wire: byte k/8, counting down from bit 7 inside the byte
    function automatic logic wire_bit(input logic [W-1:0] w, input int k);
        return w[(k / 8) * 8 + 7 - (k % 8)];
    endfunction

    // Rebuild a word from a bit stream recorded first-bit-at-MSB
    function automatic logic [W-1:0] seq_to_word(input logic [W-1:0] s);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < W; k++) r[(k / 8) * 8 + 7 - (k % 8)] = s[W - 1 - k];
        return r;
    endfunction

    // ---------------- behavioural SPI slave ----------------
    int           slv_mode = 0;          // 0: fixed reply, 1: echo previous command
    logic [W-1:0] slv_reply = 16'h1234;
    logic [W-1:0] slv_echo = '0;
    logic [W-1:0] slv_tx = '0;
    logic [W-1:0] slv_seq = '0;
    logic [W-1:0] last_seq = '0;
    int           slv_rises = 0;
    int           slv_k = 0;
    logic [W-1:0] exp_cmd_q[$];
    logic [W-1:0] exp_rsp_q[$];

    always @(negedge spi_cs_o) begin
        slv_rises = 0;
        slv_seq   = '0;
        slv_k     = 0;
        slv_tx    = (slv_mode == 0) ? slv_reply : slv_echo;
        spi_sdo_i = wire_bit(slv_tx, 0);
        exp_rsp_q.push_back(slv_tx);
    end

    always @(posedge spi_sck_o) begin
        if (!spi_cs_o) begin
            slv_seq = {slv_seq[W-2:0], spi_sdi_o};
            slv_rises++;
        end
    end

    always @(negedge spi_sck_o) begin
        if (!spi_cs_o) begin
            slv_k++;
            if (slv_k < W) spi_sdo_i = wire_bit(slv_tx, slv_k);
        end
    end

    always @(posedge spi_cs_o) begin
        if (!nreset_i) begin
            if (exp_cmd_q.size() > 0) void'(exp_cmd_q.pop_back());
            if (exp_rsp_q.size() > 0) void'(exp_rsp_q.pop_back());
        end else begin
            chk("frame_rises", slv_rises, W);
            if (exp_cmd_q.size() == 0) chk("frame_without_cmd", 1, 0);
            else chk("wire_cmd", seq_to_word(slv_seq), exp_cmd_q.pop_front());
            last_seq = slv_seq;
            slv_echo = seq_to_word(slv_seq);
        end
        spi_sdo_i = 1'b0;
    end

    // ---------------- frame timeline model ----------------
    int           cyc = 0;
    int           acc_cyc = 0;
    int           edges = 0;
    int           ph = 0;
    int           rsp_cnt = 0;
    int           last_ph = 0;
    bit           acc_vld = 1'b0;
    logic [W-1:0] cur_cmd = '0;
    logic [W-1:0] last_rsp = '0;
    int           acc_log[$];

    always @(posedge clk_i) begin
        if (nreset_i) begin
            cyc++;
            edges++;
            if (cmd_valid_i && cmd_ready_o) begin
                acc_cyc = cyc;
                acc_vld = 1'b1;
                cur_cmd = cmd_data_i;
                exp_cmd_q.push_back(cmd_data_i);
                acc_log.push_back(cyc);
            end
        end
    end

    // ph = cycles since the accepting cycle T: CS low 1..132, SCK periods from 3,
    // rsp at 133, ready again at 137
    always @(negedge clk_i) begin : cmp
        logic cs_e, sck_e, sdi_e, rdy_e, busy_e, rv_e;
        int   k;
        if (!nreset_i) begin
            acc_vld = 1'b0;
            edges   = 0;
            chk("rst_cs", spi_cs_o, 1);
            chk("rst_sck", spi_sck_o, 0);
            chk("rst_sdi", spi_sdi_o, 0);
            chk("rst_ready", cmd_ready_o, 0);
            chk("rst_rsp_valid", rsp_valid_o, 0);
            chk("rst_busy", busy_o, 0);
            chk("rst_rsp_data", rsp_data_o, 0);
        end else begin
            ph = acc_vld ? (cyc - acc_cyc + 1) : 0;
            if (acc_vld && ph > 136) begin
                acc_vld = 1'b0;
                ph      = 0;
            end
            cs_e   = 1'b1;
            sck_e  = 1'b0;
            sdi_e  = 1'b0;
            busy_e = 1'b0;
            rv_e   = 1'b0;
            rdy_e  = (edges >= 1);
            if (acc_vld) begin
                rdy_e  = 1'b0;
                busy_e = 1'b1;
                cs_e   = (ph > 132);
                sck_e  = (ph >= 3) && (ph <= 130) && (((ph - 3) % 8) >= 4);
                rv_e   = (ph == 133);
                if (ph <= 132) begin
                    k = (ph < 3) ? 0 : (ph - 3) / 8;
                    if (k > W - 1) k = W - 1;
                    sdi_e = wire_bit(cur_cmd, k);
                end
            end
            chk("cs", spi_cs_o, cs_e);
            chk("sck", spi_sck_o, sck_e);
            chk("sdi", spi_sdi_o, sdi_e);
            chk("ready", cmd_ready_o, rdy_e);
            chk("busy", busy_o, busy_e);
            chk("rsp_valid", rsp_valid_o, rv_e);
            if (rv_e && rsp_valid_o) begin
                if (exp_rsp_q.size() == 0) chk("rsp_unexpected", 1, 0);
                else chk("rsp_data", rsp_data_o, exp_rsp_q.pop_front());
                last_rsp = rsp_data_o;
                last_ph  = ph;
                rsp_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic [W-1:0] w);
        bit done;
        done = 1'b0;
        @(negedge clk_i); #1;
        cmd_valid_i = 1'b1;
        cmd_data_i  = w;
        for (int i = 0; i < 400 && !done; i++) begin
            if (cmd_ready_o) begin
                @(posedge clk_i);
                done = 1'b1;
            end else begin
                @(negedge clk_i); #1;
            end
        end
        @(negedge clk_i); #1;
        cmd_valid_i = 1'b0;
        if (!done) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_rsp(input int target);
        for (int i = 0; i < 400 && rsp_cnt < target; i++) @(negedge clk_i);
        #1;
        chk("rsp_count", rsp_cnt, target);
    endtask

    initial begin
        int n0;
        int base;
        #1 nreset_i = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("reset_ready_lit", cmd_ready_o, 0);
        chk("reset_cs_lit", spi_cs_o, 1);
        nreset_i = 1'b1;

        // Operand A write, fixed 0x1234 reply from slave
        slv_mode = 0;
        send(16'h0030);
        wait_rsp(1);
        chk("opA_wire_seq", last_seq, 16'h3000);
        chk("opA_rsp_phase", last_ph, 133);
        chk("loopback_rsp", last_rsp, 16'h1234);

        // Sobel pixel command
        send(16'h80A5);
        wait_rsp(2);
        chk("sobel_wire_seq", last_seq, 16'hA580);

        // Pipelined responses: slave returns the previous frame's word
        slv_mode = 1;
        send(16'h0030);
        wait_rsp(3);
        chk("pipe_rsp0", last_rsp, 16'h80A5);
        send(16'h2012);
        wait_rsp(4);
        chk("pipe_rsp1", last_rsp, 16'h0030);
        send(16'h0000);
        wait_rsp(5);
        chk("pipe_rsp2", last_rsp, 16'h2012);

        // Back-to-back with cmd_valid_i held high
        slv_mode = 0;
        n0 = acc_log.size();
        @(negedge clk_i); #1;
        cmd_valid_i = 1'b1;
        cmd_data_i  = 16'h1111;
        for (int i = 0; i < 300 && acc_log.size() <= n0; i++) @(negedge clk_i);
        #1;
        cmd_data_i = 16'h2222;
        for (int i = 0; i < 300 && acc_log.size() <= n0 + 1; i++) @(negedge clk_i);
        #1;
        cmd_valid_i = 1'b0;
        if (acc_log.size() >= n0 + 2) chk("bp_spacing", acc_log[n0 + 1] - acc_log[n0], 137);
        else chk("bp_second_accept", acc_log.size(), n0 + 2);
        wait_rsp(7);

        // Reset in the middle of a frame at the 5th SCK rise
        base = rsp_cnt;
        send(16'h0030);
        for (int i = 0; i < 2000 && slv_rises < 5; i++) #1;
        nreset_i = 1'b0;
        #1;
        chk("abort_cs_lit", spi_cs_o, 1);
        chk("abort_sck_lit", spi_sck_o, 0);
        chk("abort_rises", slv_rises, 5);
        repeat (3) @(negedge clk_i);
        #1;
        nreset_i = 1'b1;
        chk("abort_no_rsp", rsp_cnt, base);
        send(16'h0030);
        wait_rsp(base + 1);
        chk("after_abort_seq", last_seq, 16'h3000);
        chk("after_abort_rsp", last_rsp, 16'h1234);
        repeat (10) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
